// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants: XLEN, M-extension aluControl codes, muldiv FSM states
//
// Purpose: constants and small decode helpers shared by the ALU-side
//          multiply/divide unit. The op codes are the same 6-bit values the
//          ALU decoder drives on aluControl.
// Ports:   none (package).
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_MUL    = 6'b100111;
  localparam logic [5:0] OP_MULH   = 6'b101000;
  localparam logic [5:0] OP_MULHU  = 6'b101001;
  localparam logic [5:0] OP_MULHSU = 6'b101010;
  localparam logic [5:0] OP_DIV    = 6'b101011;
  localparam logic [5:0] OP_DIVU   = 6'b101100;
  localparam logic [5:0] OP_REM    = 6'b101101;
  localparam logic [5:0] OP_REMU   = 6'b101110;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_PREP = 2'd1,
    MD_RUN  = 2'd2,
    MD_FIX  = 2'd3
  } md_state_t;

  function automatic logic is_muldiv_op(input logic [5:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_div(input logic [5:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input logic [5:0] op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(input logic [5:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input logic [5:0] op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add / restoring-divide iteration
//
// Purpose: a single iteration of the iterative multiplier or divider.
//   Multiply: acc = {partial_hi, multiplier_remaining}; adds the multiplicand
//             to the high half when acc[0] is set, then shifts right with carry.
//   Divide:   acc = {remainder, dividend_remaining/quotient}; shifts the next
//             dividend bit into a 33-bit partial remainder and subtracts the
//             divisor if it fits.
// Ports:
//   acc_i     in  2*XLEN  accumulator (mul) or {remainder, quotient} (div)
//   operand_i in  XLEN    multiplicand magnitude (mul) or divisor magnitude (div)
//   is_div_i  in  1       1 = divide iteration, 0 = multiply iteration
//   acc_o     out 2*XLEN  next accumulator; LSB is 0 in divide mode
//   q_bit_o   out 1       quotient bit produced this iteration (0 in multiply mode)
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_bit_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   partial;
  logic [XLEN+1:0] diff;
  logic            unused_bits;

  always_comb begin
    sum = {1'b0, acc_i[2*XLEN-1:XLEN]};
    if (acc_i[0]) begin
      sum = sum + {1'b0, operand_i};
    end

    partial = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    diff    = {1'b0, partial} - {2'b00, operand_i};

    // After a successful subtract the remainder is below the divisor, so
    // the top bits of diff/partial never need to be stored.
    unused_bits = diff[XLEN] ^ partial[XLEN];

    q_bit_o = 1'b0;
    if (is_div_i) begin
      q_bit_o = ~diff[XLEN+1];
      acc_o   = {(q_bit_o ? diff[XLEN-1:0] : partial[XLEN-1:0]),
                 acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit for the execute stage
//
// Purpose: runs MUL/MULH/MULHU/MULHSU/DIV/DIVU/REM/REMU as a 32-step
//          shift-add multiplier or restoring divider on operand magnitudes,
//          with sign correction in a final FIX cycle.
//          Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed
//          overflow and multiply-by-zero skip RUN and go PREP -> FIX.
// Ports:
//   clk    in  1     rising-edge clock
//   reset  in  1     asynchronous active-high reset
//   start  in  1     request, accepted in IDLE with a valid op
//   op     in  6     aluControl encoding of the M operation
//   srcA   in  XLEN  rs1 (multiplicand / dividend), sampled on accept
//   srcB   in  XLEN  rs2 (multiplier / divisor), sampled on accept
//   flush  in  1     synchronous abort
//   busy   out 1     operation in flight
//   done   out 1     one-cycle pulse, result valid
//   result out XLEN  registered result, held until the next done
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic              mzero_q, mzero_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2*XLEN-1:0] step_acc;
  logic              step_q_bit;

  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;
  logic              special;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .is_div_i  (op_is_div(op_q)),
    .acc_o     (step_acc),
    .q_bit_o   (step_q_bit)
  );

  // Sign correction and special-case selection for the FIX cycle.
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    if (op_is_div(op_q)) begin
      // Overrides keep the ISA results correct even when RUN was skipped.
      if (div0_q) begin
        quot_fix = '1;
        rem_fix  = a_q;
      end else if (ovf_q) begin
        quot_fix = MIN_NEG;
        rem_fix  = '0;
      end
      fix_result = op_is_rem(op_q) ? rem_fix : quot_fix;
    end else if (mzero_q) begin
      fix_result = '0;
    end else if (op_q == OP_MUL) begin
      fix_result = prod_fix[XLEN-1:0];
    end else begin
      fix_result = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    mzero_d  = mzero_q;
    done_d   = 1'b0;
    result_d = result_q;

    sgn_a   = op_a_signed(op_q) & a_q[XLEN-1];
    sgn_b   = op_b_signed(op_q) & b_q[XLEN-1];
    mag_a   = sgn_a ? -a_q : a_q;
    mag_b   = sgn_b ? -b_q : b_q;
    special = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (start && !flush && is_muldiv_op(op)) begin
          state_d = MD_PREP;
          op_d    = op;
          a_d     = srcA;
          b_d     = srcB;
        end
      end

      MD_PREP: begin
        neg_a_d = sgn_a;
        neg_b_d = sgn_b;
        cnt_d   = '0;
        if (op_is_div(op_q)) begin
          opnd_d  = mag_b;
          acc_d   = {{XLEN{1'b0}}, mag_a};
          div0_d  = (b_q == '0);
          ovf_d   = op_a_signed(op_q) && (a_q == MIN_NEG) && (b_q == '1);
          mzero_d = 1'b0;
          special = div0_d | ovf_d;
        end else begin
          opnd_d  = mag_a;
          acc_d   = {{XLEN{1'b0}}, mag_b};
          div0_d  = 1'b0;
          ovf_d   = 1'b0;
          mzero_d = (a_q == '0) || (b_q == '0);
          special = mzero_d;
        end
`ifdef MULDIV_EARLY_OUT_EN
        state_d = special ? MD_FIX : MD_RUN;
`else
        state_d = MD_RUN;
`endif
      end

      MD_RUN: begin
        // In divide mode the new quotient bit enters at the LSB.
        acc_d = {step_acc[2*XLEN-1:1], step_acc[0] | step_q_bit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = MD_FIX;
        end
      end

      MD_FIX: begin
        result_d = fix_result;
        done_d   = 1'b1;
        state_d  = MD_IDLE;
      end

      default: state_d = MD_IDLE;
    endcase

    // Abort beats every in-flight update; result keeps its prior value.
    if (flush && (state_q != MD_IDLE)) begin
      state_d  = MD_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mzero_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      mzero_q  <= mzero_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != MD_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

  localparam logic [5:0] T_MUL    = 6'b100111;
  localparam logic [5:0] T_MULH   = 6'b101000;
  localparam logic [5:0] T_MULHU  = 6'b101001;
  localparam logic [5:0] T_MULHSU = 6'b101010;
  localparam logic [5:0] T_DIV    = 6'b101011;
  localparam logic [5:0] T_DIVU   = 6'b101100;
  localparam logic [5:0] T_REM    = 6'b101101;
  localparam logic [5:0] T_REMU   = 6'b101110;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [5:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  logic [5:0] op_list [8] = '{T_MUL, T_MULH, T_MULHU, T_MULHSU,
                              T_DIV, T_DIVU, T_REM, T_REMU};

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .srcA   (srcA),
    .srcB   (srcB),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      T_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      T_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      T_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      T_MULHSU: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      T_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      T_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      T_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      T_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (o inside {T_DIV, T_DIVU, T_REM, T_REMU}) begin
      if (b == 32'd0) return 2;
      if ((o inside {T_DIV, T_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    end else if (a == 32'd0 || b == 32'd0) begin
      return 2;
    end
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request and wait (bounded) for done; lat = edges after accept, -1 on timeout.
  task automatic do_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output logic busy_at_done);
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; res = 32'hDEAD_BEEF; busy_at_done = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i; res = result; busy_at_done = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, expected 0/0/0", busy, done, result);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [5:0]  vo [12] = '{T_MUL, T_MULH, T_MULHU, T_MULHSU, T_DIV, T_REM,
                             T_DIVU, T_REMU, T_DIV, T_REM, T_DIV, T_REM};
    logic [31:0] va [12] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -32'd7, -32'd7,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vr [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    int          lat;
    logic        bd;
    for (int i = 0; i < 12; i++) begin
      do_op(vo[i], va[i], vb[i], res, lat, bd);
      tests_run++;
      if (res !== vr[i]) begin
        tests_failed++;
        $display("FAIL directed_result[%0d]: op=%b a=%h b=%h got %h expected %h", i, vo[i], va[i], vb[i], res, vr[i]);
      end
      tests_run++;
      if (lat != exp_lat(vo[i], va[i], vb[i])) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(vo[i], va[i], vb[i]));
      end
      tests_run++;
      if (bd !== 1'b0) begin
        tests_failed++;
        $display("FAIL directed_busy_with_done[%0d]: busy=%b expected 0", i, bd);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  o;
    logic [31:0] a, b, res, expv;
    int          lat;
    logic        bd;
    for (int i = 0; i < 40; i++) begin
      o = op_list[$urandom_range(0, 7)];
      a = pick_operand();
      b = pick_operand();
      expv = ref_model(o, a, b);
      do_op(o, a, b, res, lat, bd);
      tests_run++;
      if (res !== expv || lat != exp_lat(o, a, b)) begin
        tests_failed++;
        $display("FAIL random[%0d]: op=%b a=%h b=%h got %h lat %0d expected %h lat %0d",
                 i, o, a, b, res, lat, expv, exp_lat(o, a, b));
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, res;
    int          lat;
    logic        bd;
    do_op(T_DIVU, 32'd100, 32'd7, prev, lat, bd);
    @(negedge clk);
    start = 1'b1; op = T_MUL; srcA = 32'd1234; srcB = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== prev) begin
      tests_failed++;
      $display("FAIL flush_abort: busy=%b done=%b result=%h expected 0/0/%h", busy, done, result, prev);
    end
    flush = 1'b0;
    do_op(T_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, res, lat, bd);
    tests_run++;
    if (res !== ref_model(T_MULHU, 32'hDEAD_BEEF, 32'h1234_5678) || lat != 34) begin
      tests_failed++;
      $display("FAIL flush_restart: got %h lat %0d expected %h lat 34", res, lat,
               ref_model(T_MULHU, 32'hDEAD_BEEF, 32'h1234_5678));
    end
  endtask

  task automatic test_start_ignored();
    int          dones = 0;
    logic [31:0] res = '0;
    @(negedge clk);
    start = 1'b1; op = T_DIV; srcA = -32'd100; srcB = 32'd9;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_after_accept: busy=%b expected 1", busy);
    end
    // Keep requesting a different op while busy; it must not be taken.
    op = T_REMU; srcA = 32'd55; srcB = 32'd4;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++; res = result;
        start = 1'b0;
      end
    end
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 6'b000000;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL invalid_op_accepted: busy=%b expected 0", busy);
    end
    @(negedge clk);
    op = T_MUL; flush = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_beats_start: busy=%b expected 0", busy);
    end
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    tests_run++;
    if (dones != 1 || res !== 32'hFFFF_FFF5) begin
      tests_failed++;
      $display("FAIL start_while_busy: dones=%0d result=%h expected 1 done, fffffff5", dones, res);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int          lat;
    logic        bd;
    do_op(T_MULH, 32'h8000_0000, 32'h8000_0000, res, lat, bd);
    tests_run++;
    if (res !== 32'h4000_0000) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h expected 40000000", res);
    end
    @(negedge clk);
    start = 1'b1; op = T_REM; srcA = 32'd17; srcB = -32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: busy=%b done=%b expected 1/0", busy, done);
    end
    lat = -1; res = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; res = result; break; end
    end
    tests_run++;
    if (res !== 32'd2 || lat != 34) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h lat %0d expected 00000002 lat 34", res, lat);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk);
    start = 1'b1; op = T_DIVU; srcA = 32'd1000; srcB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_op: busy=%b done=%b result=%h expected 0/0/0", busy, done, result);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    tests_run++;
    if (dones != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_done: dones=%0d busy=%b expected 0/0", dones, busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
